// File: rtl/pll_reconfig_ctrl.sv
// Run-time retune sequencer for the PLL OUT0 divider: power-down, DRI write and
// read-verify, release, lock wait with timeout, bounded retries, idle lock-loss watch.
module pll_reconfig_ctrl #(
    parameter logic [7:0] DIV_ADDR     = 8'h04,
    parameter logic [6:0] DIV_RESET    = 7'd15,
    parameter int         PD_CYCLES    = 16,
    parameter int         LOCK_TIMEOUT = 4096,
    parameter int         MAX_RETRY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_req,
    input  logic [6:0]  cfg_div,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic [6:0]  cur_div,
    output logic        lock_lost,
    input  logic        clr_lock_lost,
    input  logic        pll_lock,
    output logic        pll_powerdown_n,
    output logic        dri_sel,
    output logic        dri_enable,
    output logic        dri_write,
    output logic [7:0]  dri_addr,
    output logic [31:0] dri_wdata,
    input  logic [31:0] dri_rdata,
    input  logic        dri_ready
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_PD        = 4'd1;
    localparam logic [3:0] S_WR_SETUP  = 4'd2;
    localparam logic [3:0] S_WR_ACCESS = 4'd3;
    localparam logic [3:0] S_RD_SETUP  = 4'd4;
    localparam logic [3:0] S_RD_ACCESS = 4'd5;
    localparam logic [3:0] S_RELEASE   = 4'd6;
    localparam logic [3:0] S_WAIT_LOCK = 4'd7;
    localparam logic [3:0] S_DONE      = 4'd8;
    localparam logic [3:0] S_FAIL      = 4'd9;

    localparam logic [7:0]  PD_LOAD   = 8'(PD_CYCLES - 1);
    localparam logic [15:0] TMO_LOAD  = 16'(LOCK_TIMEOUT - 1);
    localparam logic [2:0]  RETRY_MAX = 3'(MAX_RETRY);

    logic [3:0]  state;
    logic [3:0]  state_nxt;
    logic [7:0]  pd_cnt;
    logic [15:0] tmo_cnt;
    logic [2:0]  retry_cnt;
    logic [6:0]  div;
    logic        lock_meta;
    logic        lock_s;
    logic        lock_prev;

    logic start;
    logic reject;
    logic rd_match;
    logic retry_take;
    logic retry_ok;
    logic in_xfer;
    logic lock_fall_idle;
    logic unused_rdata;

    assign start    = (state == S_IDLE) && cfg_req && (cfg_div != 7'd0);
    assign reject   = (state == S_IDLE) && cfg_req && (cfg_div == 7'd0);
    assign rd_match = (dri_rdata[6:0] == div);
    assign retry_ok = (retry_cnt < RETRY_MAX);
    assign retry_take = ((state == S_RD_ACCESS) && dri_ready && !rd_match) ||
                        ((state == S_WAIT_LOCK) && !lock_s && (tmo_cnt == 16'd0));
    assign unused_rdata = ^dri_rdata[31:7];

    // Lock is asynchronous to clk; everything downstream uses lock_s only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            lock_prev <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
            lock_prev <= lock_s;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (start) state_nxt = S_PD;
            S_PD:        if (pd_cnt == 8'd0) state_nxt = S_WR_SETUP;
            S_WR_SETUP:  state_nxt = S_WR_ACCESS;
            S_WR_ACCESS: if (dri_ready) state_nxt = S_RD_SETUP;
            S_RD_SETUP:  state_nxt = S_RD_ACCESS;
            S_RD_ACCESS: begin
                if (dri_ready) begin
                    if (rd_match)      state_nxt = S_RELEASE;
                    else if (retry_ok) state_nxt = S_PD;
                    else               state_nxt = S_FAIL;
                end
            end
            S_RELEASE:   state_nxt = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                if (lock_s)                    state_nxt = S_DONE;
                else if (tmo_cnt == 16'd0) begin
                    if (retry_ok)              state_nxt = S_PD;
                    else                       state_nxt = S_FAIL;
                end
            end
            S_DONE:      state_nxt = S_IDLE;
            S_FAIL:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Every entry into PD, first attempt or retry, restarts the full hold time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div       <= DIV_RESET;
            retry_cnt <= 3'd0;
            pd_cnt    <= 8'd0;
            tmo_cnt   <= 16'd0;
            cur_div   <= DIV_RESET;
        end else begin
            if (start) begin
                div       <= cfg_div;
                retry_cnt <= 3'd0;
                pd_cnt    <= PD_LOAD;
            end else if (retry_take && retry_ok) begin
                retry_cnt <= retry_cnt + 3'd1;
                pd_cnt    <= PD_LOAD;
            end else if ((state == S_PD) && (pd_cnt != 8'd0)) begin
                pd_cnt <= pd_cnt - 8'd1;
            end

            if (state == S_RELEASE) begin
                tmo_cnt <= TMO_LOAD;
            end else if ((state == S_WAIT_LOCK) && (tmo_cnt != 16'd0)) begin
                tmo_cnt <= tmo_cnt - 16'd1;
            end

            if (state == S_DONE) begin
                cur_div <= div;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_done <= (state == S_DONE);
            cfg_err  <= (state == S_FAIL) || reject;
        end
    end

    // Only a fall seen while idle and powered counts; falls we cause ourselves are ignored.
    assign lock_fall_idle = (state == S_IDLE) && pll_powerdown_n && lock_prev && !lock_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_lost <= 1'b0;
        end else if (lock_fall_idle) begin
            lock_lost <= 1'b1;
        end else if (clr_lock_lost) begin
            lock_lost <= 1'b0;
        end
    end

    assign in_xfer = (state == S_WR_SETUP) || (state == S_WR_ACCESS) ||
                     (state == S_RD_SETUP) || (state == S_RD_ACCESS);

    assign cfg_busy        = (state != S_IDLE);
    assign pll_powerdown_n = !((state == S_PD) || in_xfer);
    assign dri_sel         = in_xfer;
    assign dri_enable      = (state == S_WR_ACCESS) || (state == S_RD_ACCESS);
    assign dri_write       = (state == S_WR_SETUP) || (state == S_WR_ACCESS);
    assign dri_addr        = in_xfer ? DIV_ADDR : 8'h00;
    assign dri_wdata       = in_xfer ? {25'b0, div} : 32'h0;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Bench for pll_reconfig_ctrl: table of retune requests against a DRI register model
// and PLL lock model, plus hand sequences for lock loss, lock timeout and mid-sequence reset.
module tb_pll_reconfig_ctrl;

    localparam int T_LOCK = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_req;
    logic [6:0]  cfg_div;
    logic        cfg_busy, cfg_done, cfg_err;
    logic [6:0]  cur_div;
    logic        lock_lost;
    logic        clr_lock_lost;
    logic        pll_lock;
    logic        pll_powerdown_n;
    logic        dri_sel, dri_enable, dri_write;
    logic [7:0]  dri_addr;
    logic [31:0] dri_wdata, dri_rdata;
    logic        dri_ready;

    always #5 clk = ~clk;

    pll_reconfig_ctrl dut (
        .clk(clk), .reset(reset), .cfg_req(cfg_req), .cfg_div(cfg_div),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err), .cur_div(cur_div),
        .lock_lost(lock_lost), .clr_lock_lost(clr_lock_lost), .pll_lock(pll_lock),
        .pll_powerdown_n(pll_powerdown_n), .dri_sel(dri_sel), .dri_enable(dri_enable),
        .dri_write(dri_write), .dri_addr(dri_addr), .dri_wdata(dri_wdata),
        .dri_rdata(dri_rdata), .dri_ready(dri_ready)
    );

    // PLL model: in auto mode lock drops while powered down and returns 20 clocks after release.
    logic lock_mode = 1'b0;
    logic lock_manual = 1'b1;
    int   rel_cnt = 0;
    always @(posedge clk) begin
        if (!pll_powerdown_n) rel_cnt <= 0;
        else if (rel_cnt < 255) rel_cnt <= rel_cnt + 1;
    end
    assign pll_lock = lock_mode ? (pll_powerdown_n && (rel_cnt >= 20)) : lock_manual;

    // DRI model: one register, programmable wait states, optional corrupted first readback.
    int          wait_n = 0;
    logic        corrupt = 1'b0;
    int          acc_cnt = 0;
    logic [31:0] dri_reg = 32'd15;
    int          rd_cnt;
    assign dri_ready = dri_sel && dri_enable && (acc_cnt >= wait_n);
    assign dri_rdata = (corrupt && rd_cnt == 0) ? (dri_reg ^ 32'h1) : dri_reg;
    always @(posedge clk) begin
        if (dri_sel && dri_enable && !dri_ready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
        if (dri_sel && dri_enable && dri_ready && dri_write) dri_reg <= dri_wdata;
    end

    // Bus and pulse monitor.
    logic        mon_clear = 1'b1;
    int          wr_cnt, done_cnt, err_cnt, busy_cyc, pd_low_cyc, pd_run, last_pd_hold, acc_len, max_acc;
    logic [31:0] last_wdata;
    logic        acc_bad;
    logic        sel_prev = 1'b0, en_prev = 1'b0, wr_prev = 1'b0;
    always @(posedge clk) begin
        if (mon_clear) begin
            wr_cnt <= 0; rd_cnt <= 0; done_cnt <= 0; err_cnt <= 0; busy_cyc <= 0;
            pd_low_cyc <= 0; pd_run <= 0; last_pd_hold <= 0; acc_len <= 0; max_acc <= 0;
            last_wdata <= 32'd0; acc_bad <= 1'b0;
        end else begin
            if (dri_sel && dri_enable && dri_ready) begin
                if (dri_write) begin
                    wr_cnt <= wr_cnt + 1;
                    last_wdata <= dri_wdata;
                end else begin
                    rd_cnt <= rd_cnt + 1;
                end
            end
            if (cfg_done) done_cnt <= done_cnt + 1;
            if (cfg_err) err_cnt <= err_cnt + 1;
            if (cfg_busy) busy_cyc <= busy_cyc + 1;
            if (!pll_powerdown_n) pd_low_cyc <= pd_low_cyc + 1;
            if (!pll_powerdown_n && !dri_sel) pd_run <= pd_run + 1;
            else pd_run <= 0;
            if (dri_sel && !sel_prev) last_pd_hold <= pd_run;
            if (dri_sel && dri_enable) begin
                acc_len <= en_prev ? acc_len + 1 : 1;
                if ((en_prev ? acc_len + 1 : 1) > max_acc) max_acc <= en_prev ? acc_len + 1 : 1;
                if (dri_addr != 8'h04) acc_bad <= 1'b1;
                if (!en_prev && !sel_prev) acc_bad <= 1'b1;
                if (en_prev && (dri_write != wr_prev)) acc_bad <= 1'b1;
            end
        end
        sel_prev <= dri_sel;
        en_prev  <= dri_sel && dri_enable;
        wr_prev  <= dri_write;
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearMonitor();
        mon_clear = 1'b1;
        tick();
        mon_clear = 1'b0;
    endtask

    typedef struct {
        logic [6:0]  div;
        int          wait_n;
        logic        corrupt;
        logic        err_now;
        int          done_n;
        int          err_n;
        logic [6:0]  cur;
        int          wr_n;
        int          rd_n;
        logic [31:0] wdata;
        int          busy_n;
        int          pd_low;
        int          pd_hold;
        int          acc_max;
    } vec_t;

    vec_t vecs[5];

    task automatic applyStimulus(input vec_t v);
        wait_n  = v.wait_n;
        corrupt = v.corrupt;
        clearMonitor();
        cfg_div = v.div;
        cfg_req = 1'b1;
        tick();
        cfg_req = 1'b0;
    endtask

    task automatic checkOutput(input int i, input vec_t v);
        string p;
        p = $sformatf("vec%0d", i);
        check({p, "_done_cnt"}, done_cnt, v.done_n);
        check({p, "_err_cnt"}, err_cnt, v.err_n);
        check({p, "_cur_div"}, cur_div, v.cur);
        check({p, "_writes"}, wr_cnt, v.wr_n);
        check({p, "_reads"}, rd_cnt, v.rd_n);
        check({p, "_wdata"}, last_wdata, v.wdata);
        check({p, "_busy_cycles"}, busy_cyc, v.busy_n);
        check({p, "_pd_low_cycles"}, pd_low_cyc, v.pd_low);
        check({p, "_pd_hold"}, last_pd_hold, v.pd_hold);
        check({p, "_access_len"}, max_acc, v.acc_max);
        check({p, "_access_shape_bad"}, acc_bad, 0);
        check({p, "_busy_end"}, cfg_busy, 0);
        check({p, "_pd_n_end"}, pll_powerdown_n, 1);
        check({p, "_addr_idle"}, dri_addr, 0);
        check({p, "_lock_lost"}, lock_lost, 0);
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int hi;
        vecs[0] = '{div:7'd0,   wait_n:0, corrupt:1'b0, err_now:1'b1, done_n:0, err_n:1, cur:7'd15,
                    wr_n:0, rd_n:0, wdata:32'd0,   busy_n:0,  pd_low:0,  pd_hold:0,  acc_max:0};
        vecs[1] = '{div:7'd7,   wait_n:0, corrupt:1'b0, err_now:1'b0, done_n:1, err_n:0, cur:7'd7,
                    wr_n:1, rd_n:1, wdata:32'd7,   busy_n:44, pd_low:20, pd_hold:16, acc_max:1};
        vecs[2] = '{div:7'd127, wait_n:3, corrupt:1'b0, err_now:1'b0, done_n:1, err_n:0, cur:7'd127,
                    wr_n:1, rd_n:1, wdata:32'd127, busy_n:50, pd_low:26, pd_hold:16, acc_max:4};
        vecs[3] = '{div:7'd5,   wait_n:3, corrupt:1'b1, err_now:1'b0, done_n:1, err_n:0, cur:7'd5,
                    wr_n:2, rd_n:2, wdata:32'd5,   busy_n:76, pd_low:52, pd_hold:16, acc_max:4};
        vecs[4] = '{div:7'd0,   wait_n:0, corrupt:1'b0, err_now:1'b1, done_n:0, err_n:1, cur:7'd5,
                    wr_n:0, rd_n:0, wdata:32'd0,   busy_n:0,  pd_low:0,  pd_hold:0,  acc_max:0};

        reset = 1'b1;
        cfg_req = 1'b0;
        cfg_div = 7'd0;
        clr_lock_lost = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("reset_pd_n", pll_powerdown_n, 1);
        check("reset_cur_div", cur_div, 15);
        check("reset_busy", cfg_busy, 0);
        check("reset_done", cfg_done, 0);
        check("reset_err", cfg_err, 0);
        check("reset_sel", dri_sel, 0);
        check("reset_lock_lost", lock_lost, 0);
        repeat (3) tick();

        // Lock loss while idle, then set-wins-over-clear.
        lock_manual = 1'b0;
        tick(); tick();
        check("lock_lost_early", lock_lost, 0);
        tick();
        check("lock_lost_set", lock_lost, 1);
        clr_lock_lost = 1'b1; tick(); clr_lock_lost = 1'b0;
        check("lock_lost_clear", lock_lost, 0);
        lock_manual = 1'b1;
        repeat (4) tick();
        lock_manual = 1'b0;
        tick(); tick();
        clr_lock_lost = 1'b1; tick(); clr_lock_lost = 1'b0;
        check("lock_lost_set_wins", lock_lost, 1);
        clr_lock_lost = 1'b1; tick(); clr_lock_lost = 1'b0;
        check("lock_lost_clear2", lock_lost, 0);
        lock_manual = 1'b1;
        repeat (4) tick();
        lock_mode = 1'b1;
        repeat (4) tick();

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i]);
            check($sformatf("vec%0d_err_now", i), cfg_err, vecs[i].err_now);
            check($sformatf("vec%0d_busy_now", i), cfg_busy, !vecs[i].err_now);
            for (int c = 0; c < 500 && done_cnt == 0 && err_cnt == 0; c++) tick();
            repeat (3) tick();
            checkOutput(i, vecs[i]);
        end

        // Lock never returns: three attempts each waiting the full timeout, then one error.
        lock_manual = 1'b1;
        lock_mode = 1'b0;
        wait_n = 0;
        corrupt = 1'b0;
        repeat (4) tick();
        clearMonitor();
        cfg_div = 7'd9;
        cfg_req = 1'b1;
        tick();
        cfg_req = 1'b0;
        lock_manual = 1'b0;
        for (int a = 0; a < 3; a++) begin
            for (int c = 0; c < 200 && !pll_powerdown_n; c++) tick();
            hi = 0;
            while (pll_powerdown_n && cfg_busy && hi < T_LOCK + 10) begin
                hi++;
                tick();
            end
            check($sformatf("timeout_wait%0d", a), hi, (a == 2) ? T_LOCK + 2 : T_LOCK + 1);
        end
        check("timeout_err_pulse", cfg_err, 1);
        repeat (3) tick();
        check("timeout_err_cnt", err_cnt, 1);
        check("timeout_done_cnt", done_cnt, 0);
        check("timeout_writes", wr_cnt, 3);
        check("timeout_reads", rd_cnt, 3);
        check("timeout_pd_hold", last_pd_hold, 16);
        check("timeout_cur_div", cur_div, 5);
        check("timeout_pd_n_end", pll_powerdown_n, 1);
        check("timeout_busy_end", cfg_busy, 0);
        check("timeout_lock_lost", lock_lost, 0);

        // Asynchronous reset in the middle of the write access.
        lock_mode = 1'b1;
        wait_n = 3;
        repeat (4) tick();
        cfg_div = 7'd11;
        cfg_req = 1'b1;
        tick();
        cfg_req = 1'b0;
        for (int c = 0; c < 100 && !(dri_sel && dri_enable && dri_write); c++) tick();
        check("pre_reset_in_wr_access", dri_sel && dri_enable && dri_write, 1);
        reset = 1'b1;
        #1;
        check("midreset_pd_n", pll_powerdown_n, 1);
        check("midreset_sel", dri_sel, 0);
        check("midreset_busy", cfg_busy, 0);
        check("midreset_cur_div", cur_div, 15);
        check("midreset_done", cfg_done, 0);
        tick(); tick();
        reset = 1'b0;
        repeat (4) tick();
        wait_n = 0;
        clearMonitor();
        cfg_req = 1'b1;
        tick();
        cfg_req = 1'b0;
        for (int c = 0; c < 500 && done_cnt == 0 && err_cnt == 0; c++) tick();
        repeat (3) tick();
        check("after_reset_done_cnt", done_cnt, 1);
        check("after_reset_err_cnt", err_cnt, 0);
        check("after_reset_cur_div", cur_div, 11);
        check("after_reset_writes", wr_cnt, 1);
        check("after_reset_wdata", last_wdata, 11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_reconfig_ctrl.md
# pll_reconfig_ctrl

Sequencer that retunes the fabric PLL's OUT0 output divider at run time through the PLL's dynamic reconfiguration interface (DRI). It powers the PLL down, writes and read-verifies the divider register, releases power-down, waits for lock with a timeout, and retries a bounded number of times. It sits between a host-side config request port and the CCC/PLL instance, and monitors lock loss while idle.

## Interface

- DIV_ADDR, 8'h04: DRI address of the OUT0 divider register.
- DIV_RESET, 7'd15: divider value the PLL holds after device configuration; CUR_DIV reset value.
- PD_CYCLES, 16: power-down hold time in clocks, range 2..255.
- LOCK_TIMEOUT, 4096: clocks to wait for lock after power-down release, range 16..65535.
- MAX_RETRY, 2: retries after the first attempt, range 0..7.

Ports, as name, direction, width, meaning:

- CLK in 1: single clock for all logic, including the DRI bus.
- RESET in 1: asynchronous, active-high reset.
- CFG_REQ in 1: request a retune; sampled in IDLE only.
- CFG_DIV in 7: requested divider, captured with CFG_REQ.
- CFG_BUSY out 1: sequence in progress.
- CFG_DONE out 1: one-cycle pulse on success.
- CFG_ERR out 1: one-cycle pulse on rejection or failure.
- CUR_DIV out 7: last successfully applied divider.
- LOCK_LOST out 1: sticky; lock fell while idle.
- CLR_LOCK_LOST in 1: clears LOCK_LOST.
- PLL_LOCK in 1: asynchronous lock from the PLL.
- PLL_POWERDOWN_N out 1: PLL power-down, active-low.
- DRI_SEL, DRI_ENABLE, DRI_WRITE out 1 each: APB-style select, enable and direction.
- DRI_ADDR out 8: register address.
- DRI_WDATA out 32: write data.
- DRI_RDATA in 32: read data.
- DRI_READY in 1: transfer complete.

## Operation

- PLL_LOCK passes through a 2-flop synchronizer; all logic uses the synchronized lock (lock_s).
- States: IDLE, PD, WR_SETUP, WR_ACCESS, RD_SETUP, RD_ACCESS, RELEASE, WAIT_LOCK, DONE, FAIL.
- IDLE, on CFG_REQ=1:
  - If CFG_DIV==0: pulse CFG_ERR next cycle, stay IDLE, CUR_DIV unchanged.
  - Otherwise: capture CFG_DIV, clear the retry count, go to PD.
- PD: PLL_POWERDOWN_N=0 for PD_CYCLES clocks, then go to WR_SETUP.
- Write transfer:
  - WR_SETUP, one cycle: DRI_SEL=1, DRI_ENABLE=0, DRI_WRITE=1, DRI_ADDR=DIV_ADDR, DRI_WDATA={25'b0,div}.
  - WR_ACCESS: as WR_SETUP but DRI_ENABLE=1; hold until DRI_READY=1 is sampled, then go to RD_SETUP.
- Readback transfer:
  - RD_SETUP and RD_ACCESS follow the same shape with DRI_WRITE=0.
  - When DRI_READY=1, compare DRI_RDATA[6:0] with div.
  - Match: go to RELEASE. Mismatch: retry path.
- RELEASE, one cycle: PLL_POWERDOWN_N=1; the timeout counter loads LOCK_TIMEOUT.
- WAIT_LOCK:
  - lock_s=1: go to DONE.
  - Counter reaches 0: retry path.
- Retry path:
  - If retries < MAX_RETRY: increment the count and go to PD.
  - Otherwise: go to FAIL.
- DONE: CUR_DIV<=div, pulse CFG_DONE, go to IDLE.
- FAIL: PLL_POWERDOWN_N=1, pulse CFG_ERR, CUR_DIV unchanged, go to IDLE.
- CFG_BUSY=1 in every state except IDLE.
- CFG_REQ is ignored while busy; there is no queueing.
- DRI outputs are 0 outside the transfer states.
- LOCK_LOST:
  - Set on a falling edge of lock_s (previous 1, current 0) while IDLE and PLL_POWERDOWN_N=1.
  - Not set while busy.
  - Cleared by CLR_LOCK_LOST; if set and clear occur in the same cycle, set wins.
- DRI_READY is never timed out; a hung DRI stalls the FSM with CFG_BUSY=1 until RESET.

## Timing

- Reset values:
  - PLL_POWERDOWN_N=1 (PLL stays powered).
  - CUR_DIV=DIV_RESET.
  - State IDLE, synchronizer flops 0.
  - All other outputs 0.
- The FSM leaves IDLE on the edge after CFG_REQ. PLL_POWERDOWN_N falls and CFG_BUSY rises on that same edge.
- CFG_REQ with an invalid divider: CFG_ERR is high exactly one cycle, on the edge after the request.
- Each DRI transfer takes 2 cycles minimum (setup + access) when DRI_READY is already high; every extra cycle with READY=0 adds one cycle.
- Minimum successful sequence, no wait states and lock already high after sync: PD_CYCLES + 2 (write) + 2 (read) + 1 (RELEASE) + 2 or more (synchronizer) + 1 (DONE).
- CFG_DONE and CFG_ERR are registered, single-cycle, and mutually exclusive.
- CFG_BUSY falls in the same cycle the pulse is high.
- Lock timeout: the count starts at RELEASE; the retry path is taken LOCK_TIMEOUT cycles later if lock_s was never 1.
- RESET mid-sequence: outputs return to their reset values at once, including PLL_POWERDOWN_N=1 and CUR_DIV=DIV_RESET. No DONE or ERR pulse is produced.

## Test plan

- Nominal retune: CFG_DIV=7 and CFG_REQ pulse; DRI model with READY=1 and register echo; lock returns 20 cycles after release.
  - Required: exactly one write to 8'h04 with data 32'h7, then one read.
  - Required: PLL_POWERDOWN_N low for 16 cycles.
  - Required: one CFG_DONE pulse, CUR_DIV=7, no CFG_ERR.
- Invalid request: CFG_DIV=0.
  - Required: CFG_ERR for 1 cycle, no DRI activity, PLL_POWERDOWN_N stays 1, CUR_DIV=15.
- Lock never returns, MAX_RETRY=2.
  - Required: 3 power-down/write/read cycles, each LOCK_TIMEOUT wait observed, then one CFG_ERR.
  - Required: CUR_DIV unchanged, PLL_POWERDOWN_N=1 at end.
- Readback mismatch on the first attempt only; DRI wait states: READY held low 3 cycles per access.
  - Required: one retry, then CFG_DONE.
  - Required: each access phase lasts 4 cycles with SEL/ENABLE/ADDR stable.
- Lock loss monitoring:
  - Drop PLL_LOCK while idle → LOCK_LOST=1, 3 cycles later.
  - Assert CLR_LOCK_LOST together with a new falling edge → LOCK_LOST stays 1.
  - Drop lock during WAIT_LOCK → no LOCK_LOST.
- Reset during WR_ACCESS: assert RESET asynchronously.
  - Required: PLL_POWERDOWN_N=1, DRI_SEL=0, CFG_BUSY=0 without a clock edge; CUR_DIV=15.
  - Required: a following request completes normally.
